counter_ud_param: RTL and testbench

//  Parametrised up/down counter: generalises the fixed 8-bit enable/up_down counter.

---
 rtl/counter_pkg.sv | 25 ++
 rtl/counter_step_calc.sv | 59 +++++
 rtl/counter_ud_param.sv | 102 ++++++++++
 tb/tb_counter_ud_param.sv | 146 ++++++++++++++
 4 files changed

// File: rtl/counter_pkg.sv
// Shared types for the parametrised up/down counter: count modes, FSM states
// and the decode of the raw 2-bit mode input.
package counter_pkg;

    typedef enum logic [1:0] {
        MODE_WRAP    = 2'b00,
        MODE_SAT     = 2'b01,
        MODE_ONESHOT = 2'b10
    } mode_e;

    typedef enum logic {
        ST_RUN     = 1'b0,
        ST_STOPPED = 1'b1
    } state_e;

    // Encoding 2'b11 has no enum member of its own and behaves as WRAP.
    function automatic mode_e decode_mode(input logic [1:0] m);
        case (m)
            2'b01:   return MODE_SAT;
            2'b10:   return MODE_ONESHOT;
            default: return MODE_WRAP;
        endcase
    endfunction

endpackage

// File: rtl/counter_step_calc.sv
// Combinational next-count calculation: applies one step up or down and flags
// whether the MAX_VAL / 0 boundary was reached or crossed.
module counter_step_calc
    import counter_pkg::*;
#(
    parameter int WIDTH   = 8,
    parameter int MAX_VAL = 255,
    parameter int STEP_W  = 4
) (
    input  logic [WIDTH-1:0]  i_cur,
    input  logic [STEP_W-1:0] i_step,
    input  logic              i_up,
    input  mode_e             i_mode,
    output logic [WIDTH-1:0]  o_next,
    output logic              o_boundary,
    output logic              o_up
);

    localparam logic [WIDTH:0] LIM = (WIDTH+1)'(MAX_VAL);
    localparam logic [WIDTH:0] MOD = (WIDTH+1)'(MAX_VAL + 1);

    logic [WIDTH:0] w_cur;
    logic [WIDTH:0] w_step;
    logic [WIDTH:0] w_sum;
    logic [WIDTH:0] w_res;

    // One extra bit keeps out+step and out+MOD-step exact before the result is narrowed.
    always_comb begin
        w_cur      = {1'b0, i_cur};
        w_step     = (WIDTH+1)'(i_step);
        w_sum      = w_cur + w_step;
        w_res      = w_cur;
        o_boundary = 1'b0;
        if (i_up) begin
            if (w_sum < LIM) begin
                w_res = w_sum;
            end else begin
                o_boundary = 1'b1;
                if (i_mode == MODE_WRAP && w_sum > LIM)
                    w_res = w_sum - MOD;
                else
                    w_res = LIM;
            end
        end else begin
            if (w_step < w_cur) begin
                w_res = w_cur - w_step;
            end else begin
                o_boundary = 1'b1;
                if (i_mode == MODE_WRAP && w_step > w_cur)
                    w_res = w_cur + MOD - w_step;
                else
                    w_res = '0;
            end
        end
        o_next = WIDTH'(w_res);
        o_up   = i_up;
    end

endmodule

// File: rtl/counter_ud_param.sv
// Parametrised up/down counter with modulus, runtime step, parallel load,
// wrap/saturate/one-shot modes, terminal-count pulse and sticky boundary flags.
module counter_ud_param
    import counter_pkg::*;
#(
    parameter int WIDTH   = 8,
    parameter int MAX_VAL = 255,
    parameter int STEP_W  = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              enable,
    input  logic              up_down,
    input  logic [STEP_W-1:0] step,
    input  logic [1:0]        mode,
    input  logic              load,
    input  logic [WIDTH-1:0]  load_val,
    input  logic              clr_flags,
    output logic [WIDTH-1:0]  out,
    output logic              tc,
    output logic              ovf,
    output logic              unf,
    output logic              done
);

    localparam logic [WIDTH-1:0] MAX_V = WIDTH'(MAX_VAL);

    state_e           r_state;
    logic [WIDTH-1:0] r_out;
    logic             r_tc;
    logic             r_ovf;
    logic             r_unf;
    logic             r_done;

    mode_e            w_mode;
    logic [WIDTH-1:0] w_next;
    logic             w_boundary;
    logic             w_up;
    logic             w_count;
    logic [WIDTH-1:0] w_load_val;

    assign w_mode     = decode_mode(mode);
    assign w_count    = enable && (step != '0) && (r_state == ST_RUN);
    assign w_load_val = (load_val > MAX_V) ? MAX_V : load_val;

    counter_step_calc #(
        .WIDTH   (WIDTH),
        .MAX_VAL (MAX_VAL),
        .STEP_W  (STEP_W)
    ) u_step_calc (
        .i_cur      (r_out),
        .i_step     (step),
        .i_up       (up_down),
        .i_mode     (w_mode),
        .o_next     (w_next),
        .o_boundary (w_boundary),
        .o_up       (w_up)
    );

    // Flag clears are written first so a same-edge boundary set overrides them.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_out   <= '0;
            r_tc    <= 1'b0;
            r_ovf   <= 1'b0;
            r_unf   <= 1'b0;
            r_done  <= 1'b0;
            r_state <= ST_RUN;
        end else begin
            r_tc <= 1'b0;
            if (clr_flags) begin
                r_ovf <= 1'b0;
                r_unf <= 1'b0;
            end
            if (load) begin
                r_out   <= w_load_val;
                r_done  <= 1'b0;
                r_state <= ST_RUN;
            end else if (w_count) begin
                r_out <= w_next;
                if (w_boundary) begin
                    r_tc <= 1'b1;
                    if (w_up)
                        r_ovf <= 1'b1;
                    else
                        r_unf <= 1'b1;
                    if (w_mode == MODE_ONESHOT) begin
                        r_state <= ST_STOPPED;
                        r_done  <= 1'b1;
                    end
                end
            end
        end
    end

    assign out  = r_out;
    assign tc   = r_tc;
    assign ovf  = r_ovf;
    assign unf  = r_unf;
    assign done = r_done;

endmodule

// File: tb/tb_counter_ud_param.sv
// Directed, table-driven bench for counter_ud_param at WIDTH=8, MAX_VAL=199, STEP_W=4.
module tb_counter_ud_param;

    logic       clk = 1'b0;
    logic       reset, enable, up_down, load, clr_flags;
    logic [3:0] step;
    logic [1:0] mode;
    logic [7:0] load_val;
    logic [7:0] out;
    logic       tc, ovf, unf, done;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    counter_ud_param #(
        .WIDTH   (8),
        .MAX_VAL (199),
        .STEP_W  (4)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .enable    (enable),
        .up_down   (up_down),
        .step      (step),
        .mode      (mode),
        .load      (load),
        .load_val  (load_val),
        .clr_flags (clr_flags),
        .out       (out),
        .tc        (tc),
        .ovf       (ovf),
        .unf       (unf),
        .done      (done)
    );

    typedef struct {
        logic       rst;
        logic       en;
        logic       ud;
        logic [3:0] st;
        logic [1:0] md;
        logic       ld;
        logic [7:0] lv;
        logic       clr;
        logic [7:0] e_out;
        logic       e_tc;
        logic       e_ovf;
        logic       e_unf;
        logic       e_done;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input int rst, en, ud, st, md, ld, lv, clr,
                                input int eo, etc, eovf, eunf, edone);
        vec_t v;
        v.rst = 1'(rst); v.en = 1'(en); v.ud = 1'(ud); v.st = 4'(st);
        v.md = 2'(md); v.ld = 1'(ld); v.lv = 8'(lv); v.clr = 1'(clr);
        v.e_out = 8'(eo); v.e_tc = 1'(etc); v.e_ovf = 1'(eovf);
        v.e_unf = 1'(eunf); v.e_done = 1'(edone);
        return v;
    endfunction

    task automatic chk(input string name, input int idx, input int act, input int exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s[%0d]: got %0d expected %0d", name, idx, act, exp);
        end
    endtask

    task automatic run_vec(input vec_t v, input int idx);
        @(negedge clk);
        reset = v.rst; enable = v.en; up_down = v.ud; step = v.st; mode = v.md;
        load = v.ld; load_val = v.lv; clr_flags = v.clr;
        @(posedge clk);
        #1;
        chk("out",  idx, int'(out),  int'(v.e_out));
        chk("tc",   idx, int'(tc),   int'(v.e_tc));
        chk("ovf",  idx, int'(ovf),  int'(v.e_ovf));
        chk("unf",  idx, int'(unf),  int'(v.e_unf));
        chk("done", idx, int'(done), int'(v.e_done));
    endtask

    initial begin
        reset = 1'b1; enable = 1'b0; up_down = 1'b1; step = '0; mode = 2'b00;
        load = 1'b0; load_val = '0; clr_flags = 1'b0;

        //                 rst en ud st md ld  lv clr   out tc ovf unf done
        vecs.push_back(mk(1, 0, 1, 0, 0, 0,   0, 0,    0, 0, 0, 0, 0));
        // count up to 37, then reset (alone and with enable held)
        vecs.push_back(mk(0, 1, 1, 15, 0, 0,  0, 0,   15, 0, 0, 0, 0));
        vecs.push_back(mk(0, 1, 1, 15, 0, 0,  0, 0,   30, 0, 0, 0, 0));
        vecs.push_back(mk(0, 1, 1, 7, 0, 0,   0, 0,   37, 0, 0, 0, 0));
        vecs.push_back(mk(1, 1, 1, 7, 0, 0,   0, 0,    0, 0, 0, 0, 0));
        vecs.push_back(mk(1, 1, 1, 7, 0, 0,   0, 0,    0, 0, 0, 0, 0));
        // WRAP up past MAX: 195+7-200 = 2, then +4 = 6
        vecs.push_back(mk(0, 0, 1, 0, 0, 1, 195, 0,  195, 0, 0, 0, 0));
        vecs.push_back(mk(0, 1, 1, 7, 0, 0,   0, 0,    2, 1, 1, 0, 0));
        vecs.push_back(mk(0, 1, 1, 4, 0, 0,   0, 0,    6, 0, 1, 0, 0));
        vecs.push_back(mk(0, 0, 1, 4, 0, 0,   0, 1,    6, 0, 0, 0, 0));
        // SAT down below 0, pinned at 0 keeps pulsing tc
        vecs.push_back(mk(0, 0, 0, 9, 1, 1,   5, 0,    5, 0, 0, 0, 0));
        vecs.push_back(mk(0, 1, 0, 9, 1, 0,   0, 0,    0, 1, 0, 1, 0));
        vecs.push_back(mk(0, 1, 0, 9, 1, 0,   0, 0,    0, 1, 0, 1, 0));
        vecs.push_back(mk(0, 1, 0, 9, 1, 0,   0, 0,    0, 1, 0, 1, 0));
        vecs.push_back(mk(0, 1, 0, 9, 1, 0,   0, 0,    0, 1, 0, 1, 0));
        vecs.push_back(mk(0, 0, 0, 9, 1, 0,   0, 1,    0, 0, 0, 0, 0));
        // WRAP down landing on 0 with same-edge clr (set wins), then clr alone
        vecs.push_back(mk(0, 0, 0, 2, 0, 1,   2, 0,    2, 0, 0, 0, 0));
        vecs.push_back(mk(0, 1, 0, 2, 0, 0,   0, 1,    0, 1, 0, 1, 0));
        vecs.push_back(mk(0, 0, 0, 2, 0, 0,   0, 1,    0, 0, 0, 0, 0));
        // WRAP up landing on MAX exactly, then wrap to 0, wrap down, mode 11 = WRAP
        vecs.push_back(mk(0, 0, 1, 9, 0, 1, 190, 0,  190, 0, 0, 0, 0));
        vecs.push_back(mk(0, 1, 1, 9, 0, 0,   0, 0,  199, 1, 1, 0, 0));
        vecs.push_back(mk(0, 1, 1, 1, 0, 0,   0, 0,    0, 1, 1, 0, 0));
        vecs.push_back(mk(0, 1, 0, 3, 0, 0,   0, 0,  197, 1, 1, 1, 0));
        vecs.push_back(mk(0, 1, 1, 2, 3, 0,   0, 0,  199, 1, 1, 1, 0));
        vecs.push_back(mk(0, 1, 1, 5, 3, 0,   0, 0,    4, 1, 1, 1, 0));

        for (int i = 0; i < vecs.size(); i++)
            run_vec(vecs[i], i);

        // ONESHOT: 190 -> 195 -> 199 (done), then frozen even with mode/dir changes
        run_vec(mk(0, 0, 1, 5, 2, 1, 190, 1,  190, 0, 0, 0, 0), 100);
        run_vec(mk(0, 1, 1, 5, 2, 0,   0, 0,  195, 0, 0, 0, 0), 101);
        run_vec(mk(0, 1, 1, 5, 2, 0,   0, 0,  199, 1, 1, 0, 1), 102);
        for (int i = 0; i < 5; i++)
            run_vec(mk(0, 1, i % 2, 5, (i < 2) ? 2 : 0, 0, 0, 0, 199, 0, 1, 0, 1), 110 + i);
        run_vec(mk(0, 0, 1, 5, 2, 1,  10, 0,   10, 0, 1, 0, 0), 120);
        run_vec(mk(0, 1, 1, 5, 2, 0,   0, 0,   15, 0, 1, 0, 0), 121);

        // hold with enable low, then load beats enable (clamped), then step 0
        for (int i = 0; i < 20; i++)
            run_vec(mk(0, 0, i % 2, 1 + (i % 15), 0, 0, 0, 0, 15, 0, 1, 0, 0), 200 + i);
        run_vec(mk(0, 1, 1, 3, 0, 1, 250, 0,  199, 0, 1, 0, 0), 230);
        run_vec(mk(0, 1, 1, 0, 0, 0,   0, 0,  199, 0, 1, 0, 0), 231);
        run_vec(mk(0, 1, 0, 0, 1, 0,   0, 0,  199, 0, 1, 0, 0), 232);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
